// File: rtl/poly_add_ctrl_if.sv
// Bus bundle for poly_add_ctrl: start/status, operand RAM read port, modular-adder
// handshake and result RAM write port. op_sub exists only when POLY_SUB_EN is defined.
// master = controller side, slave = RAMs/adder/host side.
interface poly_add_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  add_enable;
  logic                  add_valid_in;
  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] add_result;
  logic                  add_valid_out;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
`ifdef POLY_SUB_EN
  logic                  op_sub;
`endif

  modport master (
`ifdef POLY_SUB_EN
    input  op_sub,
`endif
    input  start,
    input  a_rdata,
    input  b_rdata,
    input  add_result,
    input  add_valid_out,
    output busy,
    output done,
    output rd_en,
    output rd_addr,
    output add_enable,
    output add_valid_in,
    output add_a,
    output add_b,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
`ifdef POLY_SUB_EN
    output op_sub,
`endif
    output start,
    output a_rdata,
    output b_rdata,
    output add_result,
    output add_valid_out,
    input  busy,
    input  done,
    input  rd_en,
    input  rd_addr,
    input  add_enable,
    input  add_valid_in,
    input  add_a,
    input  add_b,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: streams N coefficient pairs from two operand RAMs through an external
// 3-cycle modular adder and writes the results, in order, to a result RAM.
// Optional feature: define POLY_SUB_EN to add op_sub, which turns the pass into a
// modular subtraction by feeding q-b to the adder.
module poly_add_ctrl #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned MODULUS    = 3329,
  parameter int unsigned N          = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  poly_add_ctrl_if.master bus
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0]       CntOne = CntW'(1);
  localparam logic [CntW-1:0]       LastRd = CntW'(N - 1);
  localparam logic [CntW-1:0]       AllWr  = CntW'(N);
  localparam logic [DATA_WIDTH-1:0] ModQ   = DATA_WIDTH'(MODULUS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;  // 0: read phase, 1: issue phase
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]       wr_cnt_q, wr_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  add_valid_in_q, add_valid_in_d;
  logic [DATA_WIDTH-1:0] add_a_q, add_a_d;
  logic [DATA_WIDTH-1:0] add_b_q, add_b_d;
  logic                  wr_en;
  logic                  sub_sel;
  logic [DATA_WIDTH-1:0] b_term;

`ifdef POLY_SUB_EN
  logic op_sub_q, op_sub_d;
  assign sub_sel = op_sub_q;
`else
  assign sub_sel = 1'b0;
`endif

  // Results are only accepted while a pass is live; stray or post-reset ones are dropped.
  assign wr_en = bus.add_valid_out & busy_q;

  // Operand B as fed to the adder: b for add, (q - b) mod q for subtract.
  always_comb begin
    b_term = bus.b_rdata;
    if (sub_sel) begin
      b_term = (bus.b_rdata == '0) ? '0 : (ModQ - bus.b_rdata);
    end
  end

  // FSM next state, counters and next values of all registered outputs.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    rd_en_d        = 1'b0;
    rd_addr_d      = rd_addr_q;
    add_valid_in_d = 1'b0;
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
`ifdef POLY_SUB_EN
    op_sub_d       = op_sub_q;
`endif

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + CntOne;
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StRun;
          phase_d   = 1'b0;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
`ifdef POLY_SUB_EN
          op_sub_d  = bus.op_sub;
`endif
        end
      end
      StRun: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // Read data for the previous strobe is on a/b_rdata now; launch it.
          phase_d        = 1'b0;
          add_valid_in_d = 1'b1;
          add_a_d        = bus.a_rdata;
          add_b_d        = b_term;
          rd_cnt_d       = rd_cnt_q + CntOne;
          if (rd_cnt_q == LastRd) begin
            state_d = StDrain;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_cnt_d[ADDR_WIDTH-1:0];
          end
        end
      end
      StDrain: begin
        // Leave on the edge that commits the last write so done follows it immediately.
        if (wr_cnt_d == AllWr) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      phase_q        <= 1'b0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      add_valid_in_q <= 1'b0;
      add_a_q        <= '0;
      add_b_q        <= '0;
`ifdef POLY_SUB_EN
      op_sub_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      add_valid_in_q <= add_valid_in_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
`ifdef POLY_SUB_EN
      op_sub_q       <= op_sub_d;
`endif
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.add_enable   = busy_q;
  assign bus.add_valid_in = add_valid_in_q;
  assign bus.add_a        = add_a_q;
  assign bus.add_b        = add_b_q;
  assign bus.wr_en        = wr_en;
  assign bus.wr_addr      = wr_cnt_q[ADDR_WIDTH-1:0];
  assign bus.wr_data      = bus.add_result;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Directed bench for poly_add_ctrl with behavioural operand RAMs, a 3-cycle modular
// adder and a result RAM. Build with POLY_SUB_EN defined to include the subtract test.
module tb_poly_add_ctrl;
  localparam int DW = 12;
  localparam int AW = 8;
  localparam int NC = 256;
  localparam int Q  = 3329;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
`ifdef POLY_SUB_EN
  logic op_sub = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  poly_add_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  poly_add_ctrl #(
    .DATA_WIDTH(DW),
    .MODULUS   (Q),
    .N         (NC),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int a_mem[NC];
  int b_mem[NC];
  int r_mem[NC];
  logic [DW-1:0] a_q = '0;
  logic [DW-1:0] b_q = '0;
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  int s1 = 0, s2 = 0, s3 = 0;

  assign bus.start         = start;
`ifdef POLY_SUB_EN
  assign bus.op_sub        = op_sub;
`endif
  assign bus.a_rdata       = a_q;
  assign bus.b_rdata       = b_q;
  assign bus.add_valid_out = v3;
  assign bus.add_result    = DW'(s3);

  // Operand RAMs: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      a_q <= DW'(a_mem[bus.rd_addr]);
      b_q <= DW'(b_mem[bus.rd_addr]);
    end
  end

  // Modular adder: result and valid three cycles after add_valid_in; not reset.
  always @(posedge clk) begin
    v1 <= bus.add_valid_in;
    s1 <= (int'(bus.add_a) + int'(bus.add_b)) % Q;
    v2 <= v1;
    s2 <= s1;
    v3 <= v2;
    s3 <= s2;
  end

  // Monitor: result RAM plus cumulative event/error counters.
  int wr_total = 0, done_total = 0, order_err = 0, consec_err = 0, pass_wr = 0;
  logic prev_vin = 1'b0;
  always @(posedge clk) begin
    prev_vin <= bus.add_valid_in;
    if (bus.add_valid_in && prev_vin) consec_err <= consec_err + 1;
    if (bus.done) done_total <= done_total + 1;
    if (bus.wr_en) begin
      wr_total <= wr_total + 1;
      r_mem[bus.wr_addr] <= int'(bus.wr_data);
      if (int'(bus.wr_addr) != pass_wr) order_err <= order_err + 1;
      pass_wr <= pass_wr + 1;
    end else if (!bus.busy) begin
      pass_wr <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until done is seen (bounded).
  task automatic run_pass(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({bus.busy, bus.done, bus.rd_en, bus.add_valid_in} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: got %b want 0000", k,
                 {bus.busy, bus.done, bus.rd_en, bus.add_valid_in});
      end
      total++;
      if (bus.rd_addr !== '0) begin
        bad++;
        $display("FAIL reset_rd_addr[%0d]: got %0d want 0", k, bus.rd_addr);
      end
      total++;
      if ({bus.add_a, bus.add_b} !== '0) begin
        bad++;
        $display("FAIL reset_operands[%0d]: got a=%0d b=%0d want 0", k, bus.add_a, bus.add_b);
      end
      rst = 1'b0;
      tick();
    end
  endtask

  task automatic test_basic_add();
    int cyc, w0, d0, o0, c0, exp_v, errs;
    for (int i = 0; i < NC; i++) begin
      a_mem[i] = i;
      b_mem[i] = 3000;
    end
    w0 = wr_total; d0 = done_total; o0 = order_err; c0 = consec_err;
    run_pass(cyc);
    total++;
    if (cyc != 516) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles want 516", cyc);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_in_done: got %b want 0", bus.busy);
    end
    tick();
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse_width: got %b want 0", bus.done);
    end
    tick();
    total++;
    if (wr_total - w0 != 256) begin
      bad++;
      $display("FAIL basic_write_count: got %0d want 256", wr_total - w0);
    end
    total++;
    if (done_total - d0 != 1) begin
      bad++;
      $display("FAIL basic_done_count: got %0d want 1", done_total - d0);
    end
    total++;
    if (order_err - o0 != 0) begin
      bad++;
      $display("FAIL basic_write_order: got %0d out-of-order writes want 0", order_err - o0);
    end
    total++;
    if (consec_err - c0 != 0) begin
      bad++;
      $display("FAIL issue_spacing: got %0d back-to-back issues want 0", consec_err - c0);
    end
    errs = 0;
    for (int i = 0; i < NC; i++) begin
      exp_v = (i < 329) ? i + 3000 : i - 329;
      total++;
      if (r_mem[i] != exp_v) begin
        bad++;
        errs++;
        if (errs < 5) $display("FAIL basic_data[%0d]: got %0d want %0d", i, r_mem[i], exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    for (int i = 0; i < NC; i++) begin
      a_mem[i] = i;
      b_mem[i] = i + 100;
    end
    a_mem[0] = 3328; b_mem[0] = 1;
    a_mem[1] = 3328; b_mem[1] = 0;
    a_mem[2] = 0;    b_mem[2] = 0;
    run_pass(cyc);
    tick();
    tick();
    total++;
    if (cyc != 516) begin
      bad++;
      $display("FAIL wrap_latency: got %0d want 516", cyc);
    end
    total++;
    if (r_mem[0] != 0) begin
      bad++;
      $display("FAIL wrap_3328_plus_1: got %0d want 0", r_mem[0]);
    end
    total++;
    if (r_mem[1] != 3328) begin
      bad++;
      $display("FAIL wrap_3328_plus_0: got %0d want 3328", r_mem[1]);
    end
    total++;
    if (r_mem[2] != 0) begin
      bad++;
      $display("FAIL wrap_0_plus_0: got %0d want 0", r_mem[2]);
    end
    for (int i = 3; i < NC; i += 50) begin
      total++;
      if (r_mem[i] != 2 * i + 100) begin
        bad++;
        $display("FAIL wrap_data[%0d]: got %0d want %0d", i, r_mem[i], 2 * i + 100);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, w0, d0, errs;
    for (int i = 0; i < NC; i++) begin
      a_mem[i] = 7 * i;
      b_mem[i] = 5;
    end
    w0 = wr_total; d0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    repeat (50) begin tick(); cyc++; end
    start = 1'b1;  // during RUN: must be ignored
    tick(); cyc++;
    start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 516) begin
      bad++;
      $display("FAIL b2b_latency: got %0d want 516", cyc);
    end
    start = 1'b1;  // sampled in DONE: must be ignored
    tick();
    start = 1'b0;
    repeat (6) tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_start_in_done_ignored: got busy=%b want 0", bus.busy);
    end
    total++;
    if (wr_total - w0 != 256) begin
      bad++;
      $display("FAIL b2b_write_count: got %0d want 256", wr_total - w0);
    end
    total++;
    if (done_total - d0 != 1) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d want 1", done_total - d0);
    end
    for (int i = 0; i < NC; i++) b_mem[i] = 9;
    run_pass(cyc);
    tick();
    tick();
    total++;
    if (cyc != 516) begin
      bad++;
      $display("FAIL b2b_second_latency: got %0d want 516", cyc);
    end
    errs = 0;
    for (int i = 0; i < NC; i++) begin
      total++;
      if (r_mem[i] != 7 * i + 9) begin
        bad++;
        errs++;
        if (errs < 5) $display("FAIL b2b_second_data[%0d]: got %0d want %0d", i, r_mem[i], 7 * i + 9);
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc, w0, d0, o0, errs;
    for (int i = 0; i < NC; i++) begin
      a_mem[i] = i;
      b_mem[i] = i;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (199) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.busy, bus.rd_en, bus.add_valid_in} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_abort: got busy/rd_en/vin=%b want 000",
               {bus.busy, bus.rd_en, bus.add_valid_in});
    end
    w0 = wr_total; d0 = done_total;
    repeat (20) tick();
    total++;
    if (wr_total - w0 != 0) begin
      bad++;
      $display("FAIL midrst_no_write: got %0d writes want 0", wr_total - w0);
    end
    total++;
    if (done_total - d0 != 0) begin
      bad++;
      $display("FAIL midrst_no_done: got %0d done pulses want 0", done_total - d0);
    end
    for (int i = 0; i < NC; i++) a_mem[i] = i + 1000;
    w0 = wr_total; o0 = order_err;
    run_pass(cyc);
    tick();
    tick();
    total++;
    if (cyc != 516) begin
      bad++;
      $display("FAIL midrst_new_latency: got %0d want 516", cyc);
    end
    total++;
    if (wr_total - w0 != 256 || order_err != o0) begin
      bad++;
      $display("FAIL midrst_new_writes: got %0d writes %0d order errors want 256 0",
               wr_total - w0, order_err - o0);
    end
    errs = 0;
    for (int i = 0; i < NC; i++) begin
      total++;
      if (r_mem[i] != 2 * i + 1000) begin
        bad++;
        errs++;
        if (errs < 5) $display("FAIL midrst_data[%0d]: got %0d want %0d", i, r_mem[i], 2 * i + 1000);
      end
    end
  endtask

`ifdef POLY_SUB_EN
  task automatic test_sub();
    int cyc;
    for (int i = 0; i < NC; i++) begin
      a_mem[i] = i + 500;
      b_mem[i] = i;
    end
    a_mem[0] = 5;    b_mem[0] = 10;
    a_mem[1] = 7;    b_mem[1] = 0;
    a_mem[2] = 3328; b_mem[2] = 3328;
    op_sub = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_sub = 1'b0;  // must have been captured with start
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    total++;
    if (cyc != 516) begin
      bad++;
      $display("FAIL sub_latency: got %0d want 516", cyc);
    end
    total++;
    if (r_mem[0] != 3324) begin
      bad++;
      $display("FAIL sub_5_minus_10: got %0d want 3324", r_mem[0]);
    end
    total++;
    if (r_mem[1] != 7) begin
      bad++;
      $display("FAIL sub_7_minus_0: got %0d want 7", r_mem[1]);
    end
    total++;
    if (r_mem[2] != 0) begin
      bad++;
      $display("FAIL sub_equal: got %0d want 0", r_mem[2]);
    end
    for (int i = 3; i < NC; i += 40) begin
      total++;
      if (r_mem[i] != 500) begin
        bad++;
        $display("FAIL sub_data[%0d]: got %0d want 500", i, r_mem[i]);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NC; i++) begin
      a_mem[i] = 0;
      b_mem[i] = 0;
    end
    test_reset();
    test_basic_add();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
`ifdef POLY_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
